gato_controlador_partida: RTL
=============================

// Module: gato_controlador_partida
// PURPOSE
//  Sequences one tic-tac-toe game around the cell-selection front end.
//  Accepts move requests (cell 1..9) and rejects occupied or out-of-range cells.
//  Owns the board registers, alternates turns and enforces a per-turn timeout.
//  Detects a win (8 lines) or a draw. Drives turno_p1/turno_p2 back to the selector and the board to the display.
// PARAMETERS
//  TURN_TIMEOUT  50_000_000  cycles a player may idle before the turn passes; 0 = timeout disabled
//  CNT_W         26          width of the turn counter; must hold TURN_TIMEOUT-1
// PORTS
//  clk              in   1   system clock, single clock domain, all logic on posedge
//  reset            in   1   synchronous, active-high reset
//  nuevo_juego      in   1   one-cycle strobe: clear board, start game with P1
//  jugada_valida    in   1   one-cycle strobe: move request
//  jugada_cuadro    in   4   requested cell, 1..9 (row-major, 1 = top-left)
//  jugada_ack       out  1   one-cycle pulse: move accepted and written
//  jugada_rechazo   out  1   one-cycle pulse: move refused
//  turno_p1         out  1   P1 (X) may move
//  turno_p2         out  1   P2 (O) may move
//  tablero          out  18  cell k at [2k-1:2k-2]; 00 empty, 11 P1, 01 P2
//  ganador          out  2   00 none/in play, 11 P1 won, 01 P2 won, 10 draw
//  fin_juego        out  1   game over (win or draw)
//  linea_ganadora   out  8   winning-line mask, see line order below
//  timeout_turno    out  1   one-cycle pulse: turn lost to timeout
// BEHAVIOUR
//  States: INACTIVO, TURNO_P1, TURNO_P2, EVALUA, FIN.
//  Reset values:
//   - State goes to INACTIVO. tablero=0, ganador=00, linea_ganadora=0.
//   - Turn counter=0. All outputs 0.
//  nuevo_juego:
//   - Highest priority in every state, except during reset.
//   - Next cycle: tablero=0, ganador=00, linea_ganadora=0, fin_juego=0, counter=0, state TURNO_P1.
//   - A jugada_valida in the same cycle is ignored: no ack, no rechazo.
//  Turn outputs: turno_p1=1 only in TURNO_P1; turno_p2=1 only in TURNO_P2. Both are 0 in the other states.
//  Move handling in TURNO_Px when jugada_valida=1:
//   - Accept when cuadro is 1..9 and the cell is 00.
//   - On accept: write 11 (P1) or 01 (P2) to the cell. jugada_ack=1 and the updated tablero appear the next cycle.
//     The counter clears and the state goes to EVALUA.
//   - Otherwise: jugada_rechazo=1 the next cycle. State, board and counter are unchanged.
//  jugada_valida in INACTIVO, EVALUA or FIN: jugada_rechazo pulse only.
//  EVALUA (exactly one cycle) checks the registered board:
//   - Line order for linea_ganadora bits [0..7]: {1,2,3},{4,5,6},{7,8,9},{1,4,7},{2,5,8},{3,6,9},{1,5,9},{3,5,7}.
//   - A line is set when its three cells are equal and nonzero.
//   - Any line set: ganador = that code, linea_ganadora = all set lines (two at once is legal), fin_juego=1, go to FIN.
//   - Else all 9 cells nonzero: ganador=10, fin_juego=1, go to FIN.
//   - Else go to the other player's TURNO state.
//  Latency: request in cycle N gives ack and board in N+1, and the new turn or fin_juego in N+2.
//  Timeout (TURN_TIMEOUT>0):
//   - The counter increments every cycle in TURNO_Px.
//   - At count TURN_TIMEOUT-1 with no request in that cycle: timeout_turno pulses next cycle, turn passes directly
//     to the other TURNO state (no EVALUA), and the counter clears. Board unchanged.
//   - A legal move in the same cycle as expiry wins: it is accepted and no timeout fires.
//   - A rejected move in that cycle does not stop the timeout.
//   - The counter holds 0 outside TURNO states.
//  FIN: all outputs hold until nuevo_juego or reset.
//  Reset mid-game: the state is lost and the board is cleared the next cycle, with no pulses.
//  No outputs depend combinationally on inputs; all outputs are registered.
// TESTING
//  1. Reset, nuevo_juego, then P1 plays 1,2,3 and P2 plays 4,5 alternately
//     -> ganador=11, linea_ganadora=8'h01, fin_juego=1, both turno=0.
//  2. In TURNO_P2, request cell 5 already 11 -> jugada_rechazo pulse, tablero unchanged, turno_p2 stays 1.
//  3. Requests with cuadro=0, then 10, in TURNO_P1 -> two rechazo pulses, no board change.
//  4. Full board 1..9 order X,O,X,X,O,O,O,X,X with no line
//     -> ganador=10, fin_juego=1, linea_ganadora=0.
//  5. TURN_TIMEOUT=8, no requests in TURNO_P1 -> timeout_turno 8 cycles after the turn starts, turno_p2=1.
//     Repeat with a legal move in the expiry cycle -> ack, no timeout.
//  6. nuevo_juego and jugada_valida together mid-game, then reset during EVALUA
//     -> first case: board clears and TURNO_P1 with no ack; second case: INACTIVO, all outputs 0.

Source files
------------

// File: rtl/gato_controlador_partida_if.sv
// Handshake and status bundle between the cell-selection front end and the game controller.
// The master side drives move requests; the slave side (the controller) returns turn, board and result.
interface gato_controlador_partida_if;
    logic        nuevo_juego;
    logic        jugada_valida;
    logic [3:0]  jugada_cuadro;
    logic        jugada_ack;
    logic        jugada_rechazo;
    logic        turno_p1;
    logic        turno_p2;
    logic [17:0] tablero;
    logic [1:0]  ganador;
    logic        fin_juego;
    logic [7:0]  linea_ganadora;
    logic        timeout_turno;

    modport master (
        output nuevo_juego, jugada_valida, jugada_cuadro,
        input  jugada_ack, jugada_rechazo, turno_p1, turno_p2, tablero,
               ganador, fin_juego, linea_ganadora, timeout_turno
    );

    modport slave (
        input  nuevo_juego, jugada_valida, jugada_cuadro,
        output jugada_ack, jugada_rechazo, turno_p1, turno_p2, tablero,
               ganador, fin_juego, linea_ganadora, timeout_turno
    );
endinterface

// File: rtl/gato_controlador_partida.sv
// Tic-tac-toe game sequencer: owns the board, validates moves, alternates turns,
// enforces a per-turn timeout and detects wins/draws. All outputs are registered.
module gato_controlador_partida #(
    parameter int unsigned TURN_TIMEOUT = 50_000_000,
    parameter int unsigned CNT_W        = 26
) (
    input logic                       clk,
    input logic                       reset,
    gato_controlador_partida_if.slave bus
);

    typedef enum logic [2:0] {
        INACTIVO = 3'd0,
        TURNO_P1 = 3'd1,
        TURNO_P2 = 3'd2,
        EVALUA   = 3'd3,
        FIN      = 3'd4
    } estado_t;

    localparam bit             TIMEOUT_ON = (TURN_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = TIMEOUT_ON ? CNT_W'(TURN_TIMEOUT - 1) : '0;

    // Cell indices (0-based) of each line, in linea_ganadora bit order.
    localparam int LINEA [8][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

    function automatic logic [7:0] lineas_set(input logic [17:0] t);
        logic [7:0] m;
        logic [1:0] a, b, c;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            a    = t[2*LINEA[i][0] +: 2];
            b    = t[2*LINEA[i][1] +: 2];
            c    = t[2*LINEA[i][2] +: 2];
            m[i] = (a != 2'b00) && (a == b) && (a == c);
        end
        return m;
    endfunction

    function automatic logic [1:0] codigo_ganador(input logic [17:0] t, input logic [7:0] m);
        logic [1:0] g;
        g = 2'b00;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) g = t[2*LINEA[i][0] +: 2];
        end
        return g;
    endfunction

    function automatic logic tablero_lleno(input logic [17:0] t);
        logic lleno;
        lleno = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (t[2*k +: 2] == 2'b00) lleno = 1'b0;
        end
        return lleno;
    endfunction

    estado_t          estado_q, estado_d;
    logic [17:0]      tablero_q, tablero_mov;
    logic [1:0]       ganador_q;
    logic [7:0]       linea_q;
    logic             ack_q, rechazo_q, timeout_q;
    logic [CNT_W-1:0] cnt_q;
    logic             eval_p2_q;

    logic       en_turno, cuadro_ok, celda_libre;
    logic       aceptar, rechazar, expira;
    logic [7:0] mask_eval;
    logic       lleno_eval;

    assign mask_eval  = lineas_set(tablero_q);
    assign lleno_eval = tablero_lleno(tablero_q);

    // Move decode: selected cell status and the board with the move applied.
    always_comb begin
        en_turno    = (estado_q == TURNO_P1) || (estado_q == TURNO_P2);
        cuadro_ok   = (bus.jugada_cuadro >= 4'd1) && (bus.jugada_cuadro <= 4'd9);
        celda_libre = 1'b0;
        tablero_mov = tablero_q;
        for (int k = 0; k < 9; k++) begin
            if (bus.jugada_cuadro == 4'(k + 1)) begin
                celda_libre            = (tablero_q[2*k +: 2] == 2'b00);
                tablero_mov[2*k +: 2]  = (estado_q == TURNO_P1) ? 2'b11 : 2'b01;
            end
        end
        aceptar  = !bus.nuevo_juego && en_turno && bus.jugada_valida && cuadro_ok && celda_libre;
        rechazar = !bus.nuevo_juego && bus.jugada_valida && !aceptar;
        expira   = TIMEOUT_ON && !bus.nuevo_juego && en_turno && (cnt_q == CNT_MAX) && !aceptar;
    end

    always_ff @(posedge clk) begin
        if (reset) estado_q <= INACTIVO;
        else       estado_q <= estado_d;
    end

    always_comb begin
        estado_d = estado_q;
        if (bus.nuevo_juego) begin
            estado_d = TURNO_P1;
        end else begin
            case (estado_q)
                TURNO_P1: begin
                    if (aceptar)     estado_d = EVALUA;
                    else if (expira) estado_d = TURNO_P2;
                end
                TURNO_P2: begin
                    if (aceptar)     estado_d = EVALUA;
                    else if (expira) estado_d = TURNO_P1;
                end
                EVALUA: begin
                    if ((mask_eval != 8'h00) || lleno_eval) estado_d = FIN;
                    else if (eval_p2_q)                     estado_d = TURNO_P1;
                    else                                    estado_d = TURNO_P2;
                end
                default: estado_d = estado_q;
            endcase
        end
    end

    always_comb begin
        bus.turno_p1       = (estado_q == TURNO_P1);
        bus.turno_p2       = (estado_q == TURNO_P2);
        bus.fin_juego      = (estado_q == FIN);
        bus.tablero        = tablero_q;
        bus.ganador        = ganador_q;
        bus.linea_ganadora = linea_q;
        bus.jugada_ack     = ack_q;
        bus.jugada_rechazo = rechazo_q;
        bus.timeout_turno  = timeout_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tablero_q <= '0;
            ganador_q <= 2'b00;
            linea_q   <= '0;
            ack_q     <= 1'b0;
            rechazo_q <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            eval_p2_q <= 1'b0;
        end else begin
            ack_q     <= aceptar;
            rechazo_q <= rechazar;
            timeout_q <= expira;

            if (bus.nuevo_juego || !en_turno || aceptar || expira || !TIMEOUT_ON)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + CNT_W'(1);

            if (bus.nuevo_juego) begin
                tablero_q <= '0;
                ganador_q <= 2'b00;
                linea_q   <= '0;
            end else begin
                if (aceptar) begin
                    tablero_q <= tablero_mov;
                    eval_p2_q <= (estado_q == TURNO_P2);
                end
                // Result latches on the EVALUA -> FIN transition and then holds.
                if (estado_q == EVALUA) begin
                    if (mask_eval != 8'h00) begin
                        ganador_q <= codigo_ganador(tablero_q, mask_eval);
                        linea_q   <= mask_eval;
                    end else if (lleno_eval) begin
                        ganador_q <= 2'b10;
                    end
                end
            end
        end
    end

endmodule
